// File: rtl/wb2axilite_pkg.sv
// Shared constants for the Wishbone-to-AXI4-lite bridge.
package wb2axilite_pkg;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI_PROT  = 3'b000;
  // Bufferable and modifiable.
  localparam logic [3:0] AXI_CACHE = 4'b0011;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // SLVERR and DECERR both become a WB error; OKAY and EXOKAY become an ack.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp >= RESP_SLVERR);
  endfunction

endpackage

// File: rtl/wb2axilite_respctr.sv
// Outstanding-transaction counter and flush tracking for the bridge.
// The flush flag swallows responses that belong to an aborted or failed
// WB cycle; it clears only once every in-flight transaction has returned.
module wb2axilite_respctr #(
  parameter int LGFIFO = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_accept,
  input  logic i_resp,
  input  logic i_err_set,
  input  logic i_wb_cyc,
  output logic o_full,
  output logic o_empty,
  output logic o_flushing
);

  localparam logic [LGFIFO:0] C_ONE  = {{LGFIFO{1'b0}}, 1'b1};
  localparam logic [LGFIFO:0] C_FULL = {1'b1, {LGFIFO{1'b0}}};

  logic [LGFIFO:0] r_count;
  logic [LGFIFO:0] w_count_next;
  logic            r_flush;
  logic            w_dec;

  // A response with nothing in flight (e.g. after a reset) is ignored.
  assign w_dec = i_resp && (r_count != '0);

  // Next counter value; accept and response in one cycle cancel out.
  always_comb begin
    w_count_next = r_count;
    if (i_accept && !w_dec)
      w_count_next = r_count + C_ONE;
    else if (!i_accept && w_dec)
      w_count_next = r_count - C_ONE;
  end

  // Counter and flush state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_flush <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_count_next == '0)
        r_flush <= 1'b0;
      else if (i_err_set || !i_wb_cyc)
        r_flush <= 1'b1;
    end
  end

  assign o_full     = (r_count == C_FULL);
  assign o_empty    = (r_count == '0);
  assign o_flushing = r_flush;

endmodule

// File: rtl/wb2axilite_bridge.sv
// Pipelined Wishbone slave to AXI4-lite master. Each WB strobe becomes one
// AXI-lite read or write; responses return in order as WB ack/err. Reads and
// writes are never in flight together, so ordering needs no tag FIFO.
module wb2axilite_bridge
  import wb2axilite_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGFIFO           = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_wb_cyc,
  input  logic                            i_wb_stb,
  input  logic                            i_wb_we,
  input  logic [C_AXI_ADDR_WIDTH-3:0]     i_wb_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]     i_wb_data,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   i_wb_sel,
  output logic                            o_wb_stall,
  output logic                            o_wb_ack,
  output logic                            o_wb_err,
  output logic [C_AXI_DATA_WIDTH-1:0]     o_wb_data,
  output logic                            o_axi_awvalid,
  input  logic                            i_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0]     o_axi_awaddr,
  output logic [2:0]                      o_axi_awprot,
  output logic [3:0]                      o_axi_awcache,
  output logic                            o_axi_wvalid,
  input  logic                            i_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]     o_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   o_axi_wstrb,
  input  logic                            i_axi_bvalid,
  output logic                            o_axi_bready,
  input  logic [1:0]                      i_axi_bresp,
  output logic                            o_axi_arvalid,
  input  logic                            i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0]     o_axi_araddr,
  output logic [2:0]                      o_axi_arprot,
  output logic [3:0]                      o_axi_arcache,
  input  logic                            i_axi_rvalid,
  output logic                            o_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     i_axi_rdata,
  input  logic [1:0]                      i_axi_rresp
);

  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int AW = C_AXI_ADDR_WIDTH - 2;

  logic                    r_awvalid, r_wvalid, r_arvalid;
  logic [AW+1:0]           r_awaddr, r_araddr;
  logic [DW-1:0]           r_wdata;
  logic [DW/8-1:0]         r_wstrb;
  logic                    r_dir_we;
  logic                    r_ack, r_err;
  logic [DW-1:0]           r_rdata;

  logic                    w_accept;
  logic                    w_resp;
  logic [1:0]              w_resp_code;
  logic                    w_resp_live;
  logic                    w_resp_err;
  logic                    w_full, w_empty, w_flushing;

  // Back-pressure: AXI channel blocked, window full, flushing, or direction change.
  assign o_wb_stall = (r_awvalid && !i_axi_awready)
                   || (r_wvalid  && !i_axi_wready)
                   || (r_arvalid && !i_axi_arready)
                   || w_full
                   || w_flushing
                   || (!w_empty && (i_wb_we != r_dir_we));

  assign w_accept    = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign w_resp      = i_axi_bvalid || i_axi_rvalid;
  assign w_resp_code = i_axi_bvalid ? i_axi_bresp : i_axi_rresp;
  assign w_resp_err  = resp_is_err(w_resp_code);
  // Only responses for the current, non-aborted WB cycle reach the master.
  assign w_resp_live = w_resp && i_wb_cyc && !w_flushing && !w_empty;

  wb2axilite_respctr #(
    .LGFIFO     (LGFIFO)
  ) u_respctr (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_accept   (w_accept),
    .i_resp     (w_resp),
    .i_err_set  (w_resp_live && w_resp_err),
    .i_wb_cyc   (i_wb_cyc),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_flushing (w_flushing)
  );

  // Write address/data channels: set on accept, each dropped on its own ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_accept && i_wb_we)
        r_awvalid <= 1'b1;
      else if (i_axi_awready)
        r_awvalid <= 1'b0;

      if (w_accept && i_wb_we)
        r_wvalid <= 1'b1;
      else if (i_axi_wready)
        r_wvalid <= 1'b0;

      if (w_accept && i_wb_we) begin
        r_awaddr <= {i_wb_addr, 2'b00};
        r_wdata  <= i_wb_data;
        r_wstrb  <= i_wb_sel;
      end
    end
  end

  // Read address channel and the direction of whatever is in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_dir_we  <= 1'b0;
    end else begin
      if (w_accept && !i_wb_we)
        r_arvalid <= 1'b1;
      else if (i_axi_arready)
        r_arvalid <= 1'b0;

      if (w_accept && !i_wb_we)
        r_araddr <= {i_wb_addr, 2'b00};

      if (w_accept)
        r_dir_we <= i_wb_we;
    end
  end

  // Registered WB response; read data captured on every rvalid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_resp_live && !w_resp_err;
      r_err <= w_resp_live &&  w_resp_err;
      if (i_axi_rvalid)
        r_rdata <= i_axi_rdata;
    end
  end

  assign o_wb_ack      = r_ack;
  assign o_wb_err      = r_err;
  assign o_wb_data     = r_rdata;

  assign o_axi_awvalid = r_awvalid;
  assign o_axi_awaddr  = r_awaddr;
  assign o_axi_awprot  = AXI_PROT;
  assign o_axi_awcache = AXI_CACHE;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_bready  = 1'b1;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_arprot  = AXI_PROT;
  assign o_axi_arcache = AXI_CACHE;
  assign o_axi_rready  = 1'b1;

`ifdef FORMAL
  // Local safety properties; protocol checkers attach externally.
  always @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(o_wb_ack && o_wb_err));
      assert (!(w_full && w_accept));
    end
  end
`endif

endmodule

// File: tb/tb_wb2axilite_bridge.sv
// Directed bench for the Wishbone-to-AXI4-lite bridge.
module tb_wb2axilite_bridge;

  localparam int DW  = 32;
  localparam int ADW = 28;
  localparam int AW  = ADW - 2;
  localparam int LGF = 4;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic            o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]   o_wb_data;
  logic            o_axi_awvalid, i_axi_awready;
  logic [ADW-1:0]  o_axi_awaddr;
  logic [2:0]      o_axi_awprot;
  logic [3:0]      o_axi_awcache;
  logic            o_axi_wvalid, i_axi_wready;
  logic [DW-1:0]   o_axi_wdata;
  logic [DW/8-1:0] o_axi_wstrb;
  logic            i_axi_bvalid, o_axi_bready;
  logic [1:0]      i_axi_bresp;
  logic            o_axi_arvalid, i_axi_arready;
  logic [ADW-1:0]  o_axi_araddr;
  logic [2:0]      o_axi_arprot;
  logic [3:0]      o_axi_arcache;
  logic            i_axi_rvalid, o_axi_rready;
  logic [DW-1:0]   i_axi_rdata;
  logic [1:0]      i_axi_rresp;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] rd_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  wb2axilite_bridge #(
    .C_AXI_DATA_WIDTH (DW),
    .C_AXI_ADDR_WIDTH (ADW),
    .LGFIFO           (LGF)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_wb_cyc      (i_wb_cyc),
    .i_wb_stb      (i_wb_stb),
    .i_wb_we       (i_wb_we),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_wb_sel      (i_wb_sel),
    .o_wb_stall    (o_wb_stall),
    .o_wb_ack      (o_wb_ack),
    .o_wb_err      (o_wb_err),
    .o_wb_data     (o_wb_data),
    .o_axi_awvalid (o_axi_awvalid),
    .i_axi_awready (i_axi_awready),
    .o_axi_awaddr  (o_axi_awaddr),
    .o_axi_awprot  (o_axi_awprot),
    .o_axi_awcache (o_axi_awcache),
    .o_axi_wvalid  (o_axi_wvalid),
    .i_axi_wready  (i_axi_wready),
    .o_axi_wdata   (o_axi_wdata),
    .o_axi_wstrb   (o_axi_wstrb),
    .i_axi_bvalid  (i_axi_bvalid),
    .o_axi_bready  (o_axi_bready),
    .i_axi_bresp   (i_axi_bresp),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .o_axi_araddr  (o_axi_araddr),
    .o_axi_arprot  (o_axi_arprot),
    .o_axi_arcache (o_axi_arcache),
    .i_axi_rvalid  (i_axi_rvalid),
    .o_axi_rready  (o_axi_rready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rresp   (i_axi_rresp)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 ns after the edge; outputs are checked 1-2 ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW/8-1:0] s);
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = a;
    i_wb_data = d;
    i_wb_sel  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0;
    i_axi_awready = 1'b0; i_axi_wready = 1'b0; i_axi_arready = 1'b0;
    i_axi_bvalid = 1'b0; i_axi_bresp = 2'b00;
    i_axi_rvalid = 1'b0; i_axi_rdata = '0; i_axi_rresp = 2'b00;
    repeat (3) tick();
    i_reset = 1'b0;
    #1;
    check_val("rst_awvalid", o_axi_awvalid, 0);
    check_val("rst_wvalid",  o_axi_wvalid, 0);
    check_val("rst_arvalid", o_axi_arvalid, 0);
    check_val("rst_ack",     o_wb_ack, 0);
    check_val("rst_err",     o_wb_err, 0);
    check_val("rst_data",    o_wb_data, 0);
    check_val("rst_stall",   o_wb_stall, 0);
    check_val("rst_bready",  o_axi_bready, 1);
    check_val("rst_rready",  o_axi_rready, 1);

    // Single write, slave ready immediately.
    i_axi_awready = 1'b1; i_axi_wready = 1'b1; i_axi_arready = 1'b1;
    i_wb_cyc = 1'b1;
    wb_req(1'b1, 26'h10, 32'hDEADBEEF, 4'hF);
    #1 check_val("w1_stall_pre", o_wb_stall, 0);
    tick(); i_wb_stb = 1'b0;
    #1;
    check_val("w1_awvalid", o_axi_awvalid, 1);
    check_val("w1_wvalid",  o_axi_wvalid, 1);
    check_val("w1_awaddr",  o_axi_awaddr, 28'h40);
    check_val("w1_wdata",   o_axi_wdata, 32'hDEADBEEF);
    check_val("w1_wstrb",   o_axi_wstrb, 4'hF);
    check_val("w1_awprot",  o_axi_awprot, 3'b000);
    check_val("w1_awcache", o_axi_awcache, 4'b0011);
    check_val("w1_arprot",  o_axi_arprot, 3'b000);
    check_val("w1_arcache", o_axi_arcache, 4'b0011);
    check_val("w1_arvalid", o_axi_arvalid, 0);
    tick();
    check_val("w1_awvalid_clr", o_axi_awvalid, 0);
    check_val("w1_wvalid_clr",  o_axi_wvalid, 0);
    i_axi_bvalid = 1'b1; i_axi_bresp = 2'b00;
    #1 check_val("w1_ack_early", o_wb_ack, 0);
    tick(); i_axi_bvalid = 1'b0;
    check_val("w1_ack", o_wb_ack, 1);
    check_val("w1_err", o_wb_err, 0);
    tick();
    check_val("w1_ack_clr", o_wb_ack, 0);

    // Four back-to-back reads, no stall cycles.
    for (int k = 0; k < 4; k++) begin
      wb_req(1'b0, AW'(k), '0, 4'hF);
      #1 check_val($sformatf("r4_stall_%0d", k), o_wb_stall, 0);
      tick();
      check_val($sformatf("r4_arvalid_%0d", k), o_axi_arvalid, 1);
      check_val($sformatf("r4_araddr_%0d", k), o_axi_araddr, 64'(4 * k));
    end
    i_wb_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_axi_rvalid = 1'b1; i_axi_rdata = rd_data[k];
      tick();
      check_val($sformatf("r4_ack_%0d", k), o_wb_ack, 1);
      check_val($sformatf("r4_data_%0d", k), o_wb_data, rd_data[k]);
    end
    i_axi_rvalid = 1'b0;
    tick();
    check_val("r4_ack_clr", o_wb_ack, 0);

    // awready delayed three cycles, wready immediate.
    i_axi_awready = 1'b0;
    wb_req(1'b1, 26'h5, 32'h12345678, 4'h3);
    #1 check_val("aw_stall_pre", o_wb_stall, 0);
    tick(); i_wb_stb = 1'b0;
    #1;
    check_val("aw_c1_awvalid", o_axi_awvalid, 1);
    check_val("aw_c1_wvalid",  o_axi_wvalid, 1);
    check_val("aw_c1_awaddr",  o_axi_awaddr, 28'h14);
    check_val("aw_c1_wstrb",   o_axi_wstrb, 4'h3);
    check_val("aw_c1_stall",   o_wb_stall, 1);
    tick();
    check_val("aw_c2_awvalid", o_axi_awvalid, 1);
    check_val("aw_c2_wvalid",  o_axi_wvalid, 0);
    check_val("aw_c2_stall",   o_wb_stall, 1);
    i_axi_awready = 1'b1;
    #1;
    check_val("aw_c3_awvalid", o_axi_awvalid, 1);
    check_val("aw_c3_stall",   o_wb_stall, 0);
    tick();
    check_val("aw_c4_awvalid", o_axi_awvalid, 0);
    i_axi_bvalid = 1'b1; i_axi_bresp = 2'b00;
    tick(); i_axi_bvalid = 1'b0;
    check_val("aw_ack", o_wb_ack, 1);
    tick();

    // Sixteen reads with rvalid withheld fill the window.
    for (int k = 0; k < 16; k++) begin
      wb_req(1'b0, AW'(32'h100 + k), '0, 4'hF);
      #1 check_val($sformatf("full_stall_%0d", k), o_wb_stall, 0);
      tick();
    end
    wb_req(1'b0, 26'h200, '0, 4'hF);
    #1 check_val("full_stall_17", o_wb_stall, 1);
    tick();
    check_val("full_stall_hold", o_wb_stall, 1);
    check_val("full_arvalid_clr", o_axi_arvalid, 0);
    i_axi_rvalid = 1'b1; i_axi_rdata = 32'hA0;
    #1 check_val("full_stall_rvalid", o_wb_stall, 1);
    tick(); i_axi_rvalid = 1'b0;
    check_val("full_ack_first", o_wb_ack, 1);
    check_val("full_release", o_wb_stall, 0);
    tick(); i_wb_stb = 1'b0;
    #1;
    check_val("full_17_arvalid", o_axi_arvalid, 1);
    check_val("full_17_araddr",  o_axi_araddr, 28'h800);
    check_val("full_refull",     o_wb_stall, 1);
    for (int k = 0; k < 16; k++) begin
      i_axi_rvalid = 1'b1; i_axi_rdata = DW'(k);
      tick();
      check_val($sformatf("drain_ack_%0d", k), o_wb_ack, 1);
    end
    i_axi_rvalid = 1'b0;
    tick();
    check_val("drain_ack_clr", o_wb_ack, 0);
    check_val("drain_stall", o_wb_stall, 0);

    // Three writes, the second returns SLVERR.
    for (int k = 0; k < 3; k++) begin
      wb_req(1'b1, AW'(32'h20 + k), DW'(32'h1000 + k), 4'hF);
      #1 check_val($sformatf("err_wr_stall_%0d", k), o_wb_stall, 0);
      tick();
    end
    i_wb_stb = 1'b0;
    i_axi_bvalid = 1'b1; i_axi_bresp = 2'b00;
    tick();
    check_val("err_b1_ack", o_wb_ack, 1);
    check_val("err_b1_err", o_wb_err, 0);
    i_axi_bresp = 2'b10;
    tick(); i_axi_bvalid = 1'b0;
    check_val("err_b2_ack", o_wb_ack, 0);
    check_val("err_b2_err", o_wb_err, 1);
    check_val("err_b2_stall", o_wb_stall, 1);
    tick();
    check_val("err_idle_err", o_wb_err, 0);
    check_val("err_idle_stall", o_wb_stall, 1);
    i_axi_bvalid = 1'b1; i_axi_bresp = 2'b00;
    wb_req(1'b1, 26'h30, 32'h0, 4'hF);
    #1 check_val("err_flush_stall", o_wb_stall, 1);
    tick(); i_axi_bvalid = 1'b0; i_wb_stb = 1'b0;
    check_val("err_b3_ack", o_wb_ack, 0);
    check_val("err_b3_err", o_wb_err, 0);
    check_val("err_b3_awvalid", o_axi_awvalid, 0);
    check_val("err_b3_stall", o_wb_stall, 0);

    // Read then write: write held until the read drains.
    wb_req(1'b0, 26'h30, '0, 4'hF);
    #1 check_val("dir_rd_stall", o_wb_stall, 0);
    tick();
    wb_req(1'b1, 26'h31, 32'hCAFE0001, 4'hF);
    #1 check_val("dir_wr_stall", o_wb_stall, 1);
    tick();
    check_val("dir_wr_held", o_axi_awvalid, 0);
    check_val("dir_wr_stall2", o_wb_stall, 1);
    i_axi_rvalid = 1'b1; i_axi_rdata = 32'h55;
    #1 check_val("dir_rvalid_stall", o_wb_stall, 1);
    tick(); i_axi_rvalid = 1'b0;
    check_val("dir_rd_ack", o_wb_ack, 1);
    check_val("dir_rd_data", o_wb_data, 32'h55);
    check_val("dir_release", o_wb_stall, 0);
    tick();
    check_val("dir_wr_awvalid", o_axi_awvalid, 1);
    check_val("dir_wr_awaddr", o_axi_awaddr, 28'hC4);
    check_val("dir_wr_wdata", o_axi_wdata, 32'hCAFE0001);
    wb_req(1'b1, 26'h32, 32'hCAFE0002, 4'hF);
    #1 check_val("dir_wr2_stall", o_wb_stall, 0);
    tick(); i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
    check_val("dir_wr2_awaddr", o_axi_awaddr, 28'hC8);
    tick();
    check_val("cyc_drop_stall", o_wb_stall, 1);
    i_axi_bvalid = 1'b1; i_axi_bresp = 2'b00;
    tick();
    check_val("cyc_drop_ack1", o_wb_ack, 0);
    check_val("cyc_drop_stall1", o_wb_stall, 1);
    tick(); i_axi_bvalid = 1'b0;
    check_val("cyc_drop_ack2", o_wb_ack, 0);
    check_val("cyc_drop_stall2", o_wb_stall, 0);

    // Reset mid-transaction; a late response must not disturb the counter.
    i_wb_cyc = 1'b1;
    wb_req(1'b0, 26'h40, '0, 4'hF);
    tick(); i_wb_stb = 1'b0;
    check_val("rst_mid_arvalid", o_axi_arvalid, 1);
    i_reset = 1'b1;
    tick(); i_reset = 1'b0;
    check_val("rst_mid_arvalid_clr", o_axi_arvalid, 0);
    i_axi_rvalid = 1'b1; i_axi_rdata = 32'h77;
    tick(); i_axi_rvalid = 1'b0;
    check_val("rst_late_ack", o_wb_ack, 0);
    i_wb_we = 1'b1;
    #1 check_val("rst_late_stall", o_wb_stall, 0);
    i_wb_cyc = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
